// File: rtl/tape_in_cond_if.sv
// Output bundle of the tape input conditioner: filtered level, presence flag
// and the half-period measurement with its update strobe.
interface tape_in_cond_if;
  logic        tape_in;
  logic        active;
  logic [15:0] period;
  logic        period_stb;

  modport master (output tape_in, active, period, period_stb);
  modport slave  (input  tape_in, active, period, period_stb);
endinterface

// File: rtl/tape_in_cond.sv
// Tape input conditioner: synchronizes and deglitches the shared tape/MISO pin,
// measures half-periods and qualifies a steady in-range tone as "tape present".
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no tape signal; waiting for a first in-range edge
// S_QUAL   | counting consecutive in-range edges in qcnt
// S_ACTIVE | tape present; only a full TIMEOUT without edges drops it
module tape_in_cond #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned PMIN       = 200,
  parameter int unsigned PMAX       = 4000,
  parameter int unsigned ACT_EDGES  = 16,
  parameter int unsigned TIMEOUT    = 17500
) (
  input  logic           clk28,
  input  logic           rst,
  input  logic           ck35,
  input  logic           tape_raw,
  input  logic           sd_cs,
  tape_in_cond_if.master tap
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_QUAL   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam logic [3:0]  FLEN_T = 4'(FILTER_LEN);
  localparam logic [15:0] PMIN_T = 16'(PMIN);
  localparam logic [15:0] PMAX_T = 16'(PMAX);
  localparam logic [15:0] TOUT_T = 16'(TIMEOUT);
  localparam logic [4:0]  ACT_T  = 5'(ACT_EDGES);

  logic        sync_q1, sync_q2;
  logic        level;
  logic [3:0]  run;
  logic [15:0] tick;
  logic [15:0] period_q;
  logic        stb_q;
  logic [1:0]  state;
  logic [4:0]  qcnt;

  logic        sample_diff;
  logic [3:0]  run_inc;
  logic        toggle;
  logic        in_range;
  logic        timed_out;
  logic [4:0]  qcnt_inc;

  assign sample_diff = (sync_q2 != level);
  assign run_inc     = run + 4'd1;
  assign toggle      = ck35 && sd_cs && sample_diff && (run_inc == FLEN_T);
  // tick still holds the pre-reset count on the toggle strobe, i.e. the period
  assign in_range    = (tick >= PMIN_T) && (tick <= PMAX_T);
  assign timed_out   = (tick >= TOUT_T);
  assign qcnt_inc    = qcnt + 5'd1;

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      level    <= 1'b0;
      run      <= 4'd0;
      tick     <= 16'd1;
      period_q <= 16'd0;
      stb_q    <= 1'b0;
      state    <= S_IDLE;
      qcnt     <= 5'd0;
    end else begin
      sync_q1 <= tape_raw;
      sync_q2 <= sync_q1;
      stb_q   <= 1'b0;
      if (!sd_cs) begin
        // pin carries SD data: hold the level, and restart timing on release
        run   <= 4'd0;
        tick  <= 16'd1;
        state <= S_IDLE;
        qcnt  <= 5'd0;
      end else if (ck35) begin
        if (!sample_diff) begin
          run <= 4'd0;
        end else if (toggle) begin
          run   <= 4'd0;
          level <= ~level;
        end else begin
          run <= run_inc;
        end

        if (toggle) begin
          tick     <= 16'd1;
          period_q <= tick;
          stb_q    <= 1'b1;
        end else if (tick != 16'hFFFF) begin
          tick <= tick + 16'd1;
        end

        // an edge on the timeout strobe is judged by the edge rule alone
        case (state)
          S_IDLE: begin
            if (toggle && in_range) begin
              state <= S_QUAL;
              qcnt  <= 5'd1;
            end
          end
          S_QUAL: begin
            if (toggle) begin
              if (in_range) begin
                qcnt <= qcnt_inc;
                if (qcnt_inc == ACT_T) state <= S_ACTIVE;
              end else begin
                state <= S_IDLE;
                qcnt  <= 5'd0;
              end
            end else if (timed_out) begin
              state <= S_IDLE;
              qcnt  <= 5'd0;
            end
          end
          S_ACTIVE: begin
            if (!toggle && timed_out) begin
              state <= S_IDLE;
              qcnt  <= 5'd0;
            end
          end
          default: begin
            state <= S_IDLE;
            qcnt  <= 5'd0;
          end
        endcase
      end
    end
  end

  assign tap.tape_in    = level;
  assign tap.active     = (state == S_ACTIVE);
  assign tap.period     = period_q;
  assign tap.period_stb = stb_q;

endmodule

// File: tb/tb_tape_in_cond.sv
// Directed bench for tape_in_cond: expected half-periods are queued as edges are
// driven and checked when period_stb fires; level/state checks are inline.
module tb_tape_in_cond;
  logic clk28    = 1'b0;
  logic rst      = 1'b1;
  logic ck35     = 1'b0;
  logic tape_raw = 1'b0;
  logic sd_cs    = 1'b1;
  logic slow     = 1'b0;
  int   phase    = 0;
  int   strb_cnt = 0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   exp_q[$];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;

  tape_in_cond_if tap ();

  tape_in_cond dut (
    .clk28    (clk28),
    .rst      (rst),
    .ck35     (ck35),
    .tape_raw (tape_raw),
    .sd_cs    (sd_cs),
    .tap      (tap)
  );

  always #5 clk28 = ~clk28;

  // strobe generator: every 8th cycle in slow mode, every cycle otherwise
  initial begin
    forever begin
      @(posedge clk28);
      #1;
      phase = (phase + 1) % 8;
      ck35  = slow ? (phase == 0) : 1'b1;
    end
  end

  always @(posedge clk28) begin
    if (rst) strb_cnt <= 0;
    else if (ck35) strb_cnt <= strb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk28) begin
    if (tap.period_stb) begin
      if (exp_q.size() == 0) chk("stb_when_none_expected", 32'(tap.period_stb), 32'd0);
      else chk("period", 32'(tap.period), exp_q.pop_front());
    end
  end

  task automatic edge_at(input int n, input int exp);
    repeat (n) @(posedge clk28);
    #1 tape_raw = ~tape_raw;
    exp_q.push_back(exp);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk28);
    @(negedge clk28);
  endtask

  task automatic wait_strobe();
    do @(posedge clk28); while (ck35 !== 1'b1);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk28);
    #1 rst = 1'b1;
    @(posedge clk28);
    @(negedge clk28);
    if (check) begin
      chk("rst_tape_in", 32'(tap.tape_in), 32'd0);
      chk("rst_active", 32'(tap.active), 32'd0);
      chk("rst_period", 32'(tap.period), 32'd0);
      chk("rst_stb", 32'(tap.period_stb), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      chk("rst_qcnt", 32'(dut.qcnt), 32'd0);
      chk("rst_tick", 32'(dut.tick), 32'd1);
      chk("rst_run", 32'(dut.run), 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    slow = 1'b1;
    repeat (3) @(posedge clk28);
    do_reset(1'b1);

    // glitch: 3-strobe pulse is swallowed, 4-strobe pulse passes
    wait_strobe();
    #1 tape_raw = 1'b1;
    repeat (3) wait_strobe();
    #1 tape_raw = 1'b0;
    repeat (6) wait_strobe();
    @(negedge clk28);
    chk("glitch3_tape_in", 32'(tap.tape_in), 32'd0);

    wait_strobe();
    #1 tape_raw = 1'b1;
    exp_q.push_back(strb_cnt + 4);
    repeat (3) wait_strobe();
    @(negedge clk28);
    chk("pulse4_before", 32'(tap.tape_in), 32'd0);
    wait_strobe();
    @(negedge clk28);
    chk("pulse4_rise", 32'(tap.tape_in), 32'd1);
    tape_raw = 1'b0;
    exp_q.push_back(4);
    repeat (3) wait_strobe();
    @(negedge clk28);
    chk("pulse4_hold", 32'(tap.tape_in), 32'd1);
    wait_strobe();
    @(negedge clk28);
    chk("pulse4_fall", 32'(tap.tape_in), 32'd0);
    repeat (2) wait_strobe();

    // pilot tone with every-cycle strobes
    slow = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      edge_at((i == 0) ? 2162 : 2158, 2168);
      settle();
      chk("pilot_active", 32'(tap.active), 32'(i == 15));
      if (i < 15) chk("pilot_qcnt", 32'(dut.qcnt), 32'(i + 1));
    end
    edge_at(4990, 5000);
    settle();
    chk("long_period_active", 32'(tap.active), 32'd1);
    repeat (17495) @(posedge clk28);
    @(negedge clk28);
    chk("loss_before", 32'(tap.active), 32'd1);
    @(posedge clk28);
    @(negedge clk28);
    chk("loss_after", 32'(tap.active), 32'd0);

    // period bounds
    tape_raw = 1'b0;
    do_reset(1'b0);
    edge_at(193, 199);
    settle();
    chk("b199_state", 32'(dut.state), 32'(IDLE));
    edge_at(190, 200);
    settle();
    chk("b200_state", 32'(dut.state), 32'(QUAL));
    chk("b200_qcnt", 32'(dut.qcnt), 32'd1);
    edge_at(3990, 4000);
    settle();
    chk("b4000_state", 32'(dut.state), 32'(QUAL));
    chk("b4000_qcnt", 32'(dut.qcnt), 32'd2);
    edge_at(3991, 4001);
    settle();
    chk("b4001_state", 32'(dut.state), 32'(IDLE));
    chk("b4001_qcnt", 32'(dut.qcnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      edge_at(190, 200);
      settle();
      chk("b200_active", 32'(tap.active), 32'(i == 15));
    end

    // reset in ACTIVE with tape_in high, then fresh qualification
    edge_at(190, 200);
    settle();
    chk("pre_rst_tape_in", 32'(tap.tape_in), 32'd1);
    tape_raw = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      edge_at((i == 0) ? 194 : 190, 200);
      settle();
      chk("requal_active", 32'(tap.active), 32'(i == 15));
    end

    // SD sharing
    edge_at(190, 200);
    settle();
    sd_cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (300) @(posedge clk28);
      #1 tape_raw = ~tape_raw;
    end
    settle();
    chk("sd_active", 32'(tap.active), 32'd0);
    chk("sd_qcnt", 32'(dut.qcnt), 32'd0);
    chk("sd_tape_in", 32'(tap.tape_in), 32'd1);
    chk("sd_run", 32'(dut.run), 32'd0);
    sd_cs = 1'b1;
    edge_at(300, 306);
    settle();
    chk("sd_rel_state", 32'(dut.state), 32'(QUAL));
    chk("sd_rel_tape_in", 32'(tap.tape_in), 32'd0);

    repeat (5) @(posedge clk28);
    @(negedge clk28);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
